// File: rtl/ov5640_init_seq.sv
`timescale 1ns/1ps
// ov5640_init_seq
// Walks the OV5640 register table ROM and feeds each {reg_addr[15:0], value[7:0]}
// word to the 3-byte I2C write engine through its sendit/done handshake.
// Table codes: addr 16'hFFFE ends the table, addr 16'hFFFF waits value[7:0] ms.
// NACKed writes are resent up to MAX_RETRY times; a NACK beyond that or a stalled
// engine stops the walk with error set and fail_index naming the entry.
//
// Ports:
//   meg25         25 MHz system clock
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse, honoured only when no sequence is running
//   rom_addr      table index (registered ROM: rom_data follows one cycle later)
//   rom_data      table word
//   i2c_send_dat  word handed to the I2C engine, stable while a write is open
//   i2c_sendit    transfer request to the I2C engine
//   i2c_done      engine idle flag (engine clock domain)
//   i2c_ack       1 = NACK seen on the last transfer (engine clock domain)
//   busy          sequence in progress
//   initial_done  table completed, sticky until the next start
//   error         retries or timeout exhausted, sticky until the next start
//   fail_index    table index of the failing entry while error is set
module ov5640_init_seq #(
    parameter int ADDR_W         = 8,
    parameter int NUM_ENTRIES    = 255,
    parameter int PWRUP_CYCLES   = 500000,
    parameter int GAP_CYCLES     = 125,
    parameter int MS_CYCLES      = 25000,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 262143
) (
    input  logic              meg25,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [23:0]       i2c_send_dat,
    output logic              i2c_sendit,
    input  logic              i2c_done,
    input  logic              i2c_ack,
    output logic              busy,
    output logic              initial_done,
    output logic              error,
    output logic [ADDR_W-1:0] fail_index
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_DECODE,
        ST_DELAY,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // One shared dwell counter serves every timed state, so it must hold the
    // longest of the power-up wait, a 255 ms delay, the gap and the timeout.
    localparam longint DLY_MAX   = 255 * longint'(MS_CYCLES);
    localparam longint CNT_MAX_A = (longint'(PWRUP_CYCLES) > DLY_MAX) ? longint'(PWRUP_CYCLES) : DLY_MAX;
    localparam longint CNT_MAX_B = (TIMEOUT_CYCLES > GAP_CYCLES) ? longint'(TIMEOUT_CYCLES) : longint'(GAP_CYCLES);
    localparam longint CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int     CNT_W     = (CNT_MAX < 255) ? 8 : $clog2(CNT_MAX + 1);
    localparam int     RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // The walk bound is clamped to the last addressable entry so rom_addr can
    // never wrap back into the table.
    localparam int ADDR_TOP  = (1 << ADDR_W) - 1;
    localparam int LAST_IDX  = (NUM_ENTRIES > ADDR_TOP) ? ADDR_TOP : NUM_ENTRIES;

    localparam logic [CNT_W-1:0]   PWRUP_LAST  = CNT_W'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   MS_CNT      = CNT_W'(MS_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0]  LAST_ENTRY  = ADDR_W'(LAST_IDX);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   dly_last;
    logic [RETRY_W-1:0] retry;
    logic               resend;
    logic               armed;
    logic               done_meta_p0;
    logic               done_sync_p1;
    logic               ack_meta_p0;
    logic               ack_sync_p1;

    logic               sendit_nxt;
    logic               busy_nxt;
    logic               advance;
    logic               launch;
    logic               seq_start;
    logic               end_hit;
    logic               is_delay;
    logic               zero_delay;

    // Last dwell-counter value of a value[7:0] millisecond delay.
    function automatic logic [CNT_W-1:0] ms_to_last(input logic [7:0] ms);
        logic [CNT_W-1:0] cycles;
        cycles = CNT_W'(ms) * MS_CNT;
        return cycles - CNT_W'(1);
    endfunction

    assign end_hit    = (rom_data[23:8] == 16'hFFFE) || (rom_addr == LAST_ENTRY);
    assign is_delay   = (rom_data[23:8] == 16'hFFFF);
    assign zero_delay = (rom_data[7:0] == 8'd0);

    // State register
    always_ff @(posedge meg25 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start && armed) next_state = ST_PWRUP;
            end
            ST_PWRUP: begin
                if (cnt >= PWRUP_LAST) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (end_hit)         next_state = ST_DONE;
                else if (is_delay)   next_state = zero_delay ? ST_FETCH : ST_DELAY;
                else                 next_state = ST_WAIT_BUSY;
            end
            ST_DELAY: begin
                if (cnt >= dly_last) next_state = ST_FETCH;
            end
            ST_WAIT_BUSY: begin
                if (!done_sync_p1)           next_state = ST_WAIT_DONE;
                else if (cnt >= TIMEOUT_LIM) next_state = ST_ERROR;
            end
            ST_WAIT_DONE: begin
                if (done_sync_p1)            next_state = ST_CHECK;
                else if (cnt >= TIMEOUT_LIM) next_state = ST_ERROR;
            end
            ST_CHECK: begin
                if (ack_sync_p1 && (retry == RETRY_LIM)) next_state = ST_ERROR;
                else                                     next_state = ST_GAP;
            end
            ST_GAP: begin
                if (cnt >= GAP_LAST) next_state = resend ? ST_DECODE : ST_FETCH;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output / control decode. sendit and busy are registered from the next
    // state so the request line toward the engine domain is glitch-free.
    always_comb begin
        sendit_nxt = (next_state == ST_WAIT_BUSY) || (next_state == ST_WAIT_DONE);
        busy_nxt   = !((next_state == ST_IDLE) || (next_state == ST_DONE) || (next_state == ST_ERROR));
        seq_start  = ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR))
                     && (next_state == ST_PWRUP);
        // Every entry into FETCH except the one after power-up moves to the next entry.
        advance    = (next_state == ST_FETCH) && (state != ST_PWRUP);
        launch     = (state == ST_DECODE) && (next_state == ST_WAIT_BUSY);
    end

    // Stage p0/p1: two-flop synchronisers for the engine-domain flags
    always_ff @(posedge meg25 or negedge reset_n) begin
        if (!reset_n) begin
            done_meta_p0 <= 1'b0;
            done_sync_p1 <= 1'b0;
            ack_meta_p0  <= 1'b0;
            ack_sync_p1  <= 1'b0;
        end else begin
            done_meta_p0 <= i2c_done;
            done_sync_p1 <= done_meta_p0;
            ack_meta_p0  <= i2c_ack;
            ack_sync_p1  <= ack_meta_p0;
        end
    end

    // Sequencer datapath and status registers
    always_ff @(posedge meg25 or negedge reset_n) begin
        if (!reset_n) begin
            armed        <= 1'b0;
            cnt          <= '0;
            dly_last     <= '0;
            retry        <= '0;
            resend       <= 1'b0;
            rom_addr     <= '0;
            i2c_send_dat <= '0;
            i2c_sendit   <= 1'b0;
            busy         <= 1'b0;
            initial_done <= 1'b0;
            error        <= 1'b0;
            fail_index   <= '0;
        end else begin
            // Blocks a start pulse that lands on the first edge after reset release.
            armed      <= 1'b1;
            i2c_sendit <= sendit_nxt;
            busy       <= busy_nxt;

            if ((next_state != state) || !busy_nxt) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (seq_start) begin
                rom_addr     <= '0;
                retry        <= '0;
                resend       <= 1'b0;
                initial_done <= 1'b0;
                error        <= 1'b0;
                fail_index   <= '0;
            end

            if (advance) begin
                rom_addr <= rom_addr + ADDR_W'(1);
            end

            if (state == ST_DECODE) begin
                dly_last <= ms_to_last(rom_data[7:0]);
            end

            if (launch) begin
                i2c_send_dat <= rom_data;
            end

            if (state == ST_CHECK) begin
                if (!ack_sync_p1) begin
                    retry  <= '0;
                    resend <= 1'b0;
                end else if (retry != RETRY_LIM) begin
                    retry  <= retry + RETRY_W'(1);
                    resend <= 1'b1;
                end
            end

            if ((state == ST_DECODE) && (next_state == ST_DONE)) begin
                initial_done <= 1'b1;
            end

            if ((next_state == ST_ERROR) && (state != ST_ERROR)) begin
                error      <= 1'b1;
                fail_index <= rom_addr;
            end
        end
    end

endmodule

// File: tb/tb_ov5640_init_seq.sv
`timescale 1ns/1ps
// tb_ov5640_init_seq
// Randomised and directed stimulus for ov5640_init_seq with a behavioural I2C
// engine, a registered table ROM, and a scoreboard of expected I2C frames.
module tb_ov5640_init_seq;

    localparam int ADDR_W         = 4;
    localparam int NUM_ENTRIES    = 12;
    localparam int PWRUP_CYCLES   = 40;
    localparam int GAP_CYCLES     = 6;
    localparam int MS_CYCLES      = 20;
    localparam int MAX_RETRY      = 3;
    localparam int TIMEOUT_CYCLES = 300;

    logic              meg25 = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic [23:0]       i2c_send_dat;
    logic              i2c_sendit;
    logic              i2c_done = 1'b1;
    logic              i2c_ack = 1'b0;
    logic              busy;
    logic              initial_done;
    logic              error;
    logic [ADDR_W-1:0] fail_index;

    always #20 meg25 = ~meg25;

    ov5640_init_seq #(
        .ADDR_W        (ADDR_W),
        .NUM_ENTRIES   (NUM_ENTRIES),
        .PWRUP_CYCLES  (PWRUP_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES),
        .MS_CYCLES     (MS_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .meg25       (meg25),
        .reset_n     (reset_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .i2c_send_dat(i2c_send_dat),
        .i2c_sendit  (i2c_sendit),
        .i2c_done    (i2c_done),
        .i2c_ack     (i2c_ack),
        .busy        (busy),
        .initial_done(initial_done),
        .error       (error),
        .fail_index  (fail_index)
    );

    // Table ROM with one cycle of read latency, and per-entry NACK counts.
    logic [23:0] tbl [16];
    int          nack_plan [16];

    always @(posedge meg25) rom_data <= tbl[rom_addr];

    typedef struct { logic [23:0] word; int min_cyc; } exp_t;
    typedef struct { logic [23:0] word; int cyc; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    logic ack_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit stuck = 1'b0;
    int busy_min = 3;
    int busy_max = 30;
    int eng_frames = 0;
    int eng_st = 0;
    int eng_cnt = 0;
    int rise_cyc = 0;
    int lat = 0;
    obs_t mon_o;
    exp_t mon_e;

    always @(posedge meg25) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_cond(input string name, input bit ok, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, bound %0d", name, act, req);
        end
    endtask

    // Behavioural I2C engine: accepts a request after a short random latency,
    // stays busy for a random time, then reports the planned ACK/NACK.
    always @(negedge meg25) begin
        if (!reset_n) begin
            eng_st   = 0;
            i2c_done = 1'b1;
            i2c_ack  = 1'b0;
        end else begin
            case (eng_st)
                0: if (i2c_sendit && !stuck) begin
                    eng_cnt = $urandom_range(4, 1);
                    eng_st  = 1;
                end
                1: begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        i2c_done = 1'b0;
                        obs_q.push_back('{i2c_send_dat, cyc - start_cyc});
                        eng_frames++;
                        eng_cnt = $urandom_range(busy_max, busy_min);
                        eng_st  = 2;
                    end
                end
                2: begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        i2c_ack  = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                        i2c_done = 1'b1;
                        rise_cyc = cyc;
                        eng_st   = 3;
                    end
                end
                3: begin
                    lat = cyc - rise_cyc;
                    if (!i2c_sendit) begin
                        chk_cond("sendit_fall_latency", lat <= 3, lat, 3);
                        eng_st = 0;
                    end else if (lat > 10) begin
                        chk_cond("sendit_fall_latency", 1'b0, lat, 3);
                        eng_st = 4;
                    end
                end
                default: if (!i2c_sendit) eng_st = 0;
            endcase
        end
    end

    // Monitor: each frame the engine takes is checked against the next expected one.
    always @(posedge meg25) begin
        while (obs_q.size() > 0) begin
            mon_o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected: got %06h, expected no frame", mon_o.word);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_word", 32'(mon_o.word), 32'(mon_e.word));
                chk_cond("frame_not_early", mon_o.cyc >= mon_e.min_cyc, mon_o.cyc, mon_e.min_cyc);
            end
        end
    end

    // Reference model: walks the table by its rules and lists the frames the
    // engine should see, the ACK pattern to return, and the final status.
    task automatic build_model(output bit e_done, output bit e_err, output int e_addr);
        int delay_acc;
        bit nacked;
        exp_q.delete();
        ack_q.delete();
        delay_acc = PWRUP_CYCLES;
        e_done = 1'b0;
        e_err  = 1'b0;
        e_addr = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == NUM_ENTRIES || tbl[i][23:8] == 16'hFFFE) begin
                e_done = 1'b1;
                e_addr = i;
                break;
            end
            if (tbl[i][23:8] == 16'hFFFF) begin
                delay_acc += int'(tbl[i][7:0]) * MS_CYCLES;
                continue;
            end
            for (int a = 0; a <= MAX_RETRY; a++) begin
                nacked = (a < nack_plan[i]);
                exp_q.push_back('{tbl[i], delay_acc});
                ack_q.push_back(nacked);
                if (!nacked) break;
            end
            if (nack_plan[i] > MAX_RETRY) begin
                e_err  = 1'b1;
                e_addr = i;
                break;
            end
        end
    endtask

    task automatic clear_table;
        for (int i = 0; i < 16; i++) begin
            tbl[i]       = {16'($urandom_range(16'hFFFD, 0)), 8'($urandom_range(255, 0))};
            nack_plan[i] = 0;
        end
    endtask

    task automatic pulse_start;
        @(negedge meg25);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge meg25);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge meg25);
            n++;
        end
        chk("sequence_ends_in_budget", 32'(busy), 32'(0));
    endtask

    // Runs one sequence from start to completion and checks the end status.
    // poke_decode1 pulses start again while entry 1 is being decoded.
    task automatic run_and_check(input bit poke_decode1);
        bit ed, ee;
        int ea, n;
        build_model(ed, ee, ea);
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'(1));
        chk("error_cleared_by_start", 32'(error), 32'(0));
        chk("done_cleared_by_start", 32'(initial_done), 32'(0));
        chk("rom_addr_zero_after_start", 32'(rom_addr), 32'(0));
        if (poke_decode1) begin
            n = 0;
            while (rom_addr != ADDR_W'(1) && n < 5000) begin
                @(negedge meg25);
                n++;
            end
            chk("reached_entry1", 32'(rom_addr), 32'(1));
            @(negedge meg25);
            start = 1'b1;
            @(negedge meg25);
            start = 1'b0;
        end
        wait_idle(20000);
        repeat (2) @(negedge meg25);
        chk("initial_done_end", 32'(initial_done), 32'(ed));
        chk("error_end", 32'(error), 32'(ee));
        chk("rom_addr_end", 32'(rom_addr), 32'(ea));
        if (ee) chk("fail_index_end", 32'(fail_index), 32'(ea));
        chk("sendit_low_end", 32'(i2c_sendit), 32'(0));
        chk("all_frames_seen", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int n;
        int idx;
        int r;
        bit ed, ee;
        int ea;

        clear_table();

        // Reset values
        #5 reset_n = 1'b0;
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_send_dat", 32'(i2c_send_dat), 32'(0));
        chk("rst_sendit", 32'(i2c_sendit), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_initial_done", 32'(initial_done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_fail_index", 32'(fail_index), 32'(0));
        repeat (3) @(negedge meg25);
        reset_n = 1'b1;
        repeat (2) @(negedge meg25);

        // Two writes then end marker, with a stray start during entry 1 decode
        clear_table();
        tbl[0] = 24'h310311; tbl[1] = 24'h300882; tbl[2] = 24'hFFFE00;
        run_and_check(1'b1);

        // Delay entry of 5 ms before the first write
        clear_table();
        tbl[0] = 24'hFFFF05; tbl[1] = 24'h310311; tbl[2] = 24'hFFFE00;
        run_and_check(1'b0);

        // Entry 1 NACKed twice, then ACKed
        clear_table();
        tbl[0] = 24'h310311; tbl[1] = 24'h300882; tbl[2] = 24'h300903; tbl[3] = 24'hFFFE00;
        nack_plan[1] = 2;
        run_and_check(1'b0);

        // Entry 2 always NACKed: retries exhausted
        clear_table();
        tbl[0] = 24'h310311; tbl[1] = 24'h300882; tbl[2] = 24'h300903; tbl[3] = 24'hFFFE00;
        nack_plan[2] = 4;
        run_and_check(1'b0);

        // No end marker: walk stops at the entry bound
        clear_table();
        run_and_check(1'b0);

        // Engine never leaves idle: timeout, then a clean restart
        clear_table();
        exp_q.delete();
        ack_q.delete();
        stuck = 1'b1;
        pulse_start();
        wait_idle(5000);
        chk("timeout_error", 32'(error), 32'(1));
        chk("timeout_fail_index", 32'(fail_index), 32'(0));
        chk("timeout_initial_done", 32'(initial_done), 32'(0));
        chk("timeout_sendit", 32'(i2c_sendit), 32'(0));
        stuck = 1'b0;
        tbl[0] = 24'h310311; tbl[1] = 24'h300882; tbl[2] = 24'hFFFE00;
        run_and_check(1'b0);

        // Reset asserted while the engine is busy on entry 1
        clear_table();
        tbl[0] = 24'h310311; tbl[1] = 24'h300882; tbl[2] = 24'hFFFE00;
        busy_min = 50;
        busy_max = 60;
        build_model(ed, ee, ea);
        pulse_start();
        n = 0;
        while (!(eng_frames > 0 && eng_st == 2 && rom_addr == ADDR_W'(1)) && n < 5000) begin
            @(negedge meg25);
            n++;
        end
        chk("reached_entry1_transfer", 32'(rom_addr), 32'(1));
        repeat (10) @(negedge meg25);
        #5 reset_n = 1'b0;
        #1;
        chk("midrst_sendit", 32'(i2c_sendit), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_rom_addr", 32'(rom_addr), 32'(0));
        chk("midrst_send_dat", 32'(i2c_send_dat), 32'(0));
        chk("midrst_error", 32'(error), 32'(0));
        chk("midrst_initial_done", 32'(initial_done), 32'(0));
        exp_q.delete();
        ack_q.delete();
        @(negedge meg25);
        @(negedge meg25);
        reset_n = 1'b1;
        start   = 1'b1;
        @(negedge meg25);
        start = 1'b0;
        repeat (4) @(negedge meg25);
        chk("start_at_reset_release_ignored", 32'(busy), 32'(0));
        busy_min = 3;
        busy_max = 30;

        // Randomised tables
        for (int t = 0; t < 6; t++) begin
            clear_table();
            idx = 0;
            n = $urandom_range(5, 1);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) == 0) begin
                    tbl[idx] = {16'hFFFF, 8'($urandom_range(3, 0))};
                    idx++;
                end
                r = $urandom_range(9, 0);
                nack_plan[idx] = (r < 5) ? 0 : ((r < 8) ? r - 4 : 4);
                idx++;
            end
            tbl[idx] = 24'hFFFE00;
            run_and_check(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ov5640_init_seq.md
Name: ov5640_init_seq

Overview:
- Sequences the OV5640 camera register initialisation by feeding 24-bit {reg_addr[15:0], value[7:0]} words, one at a time, to the existing 3-byte I2C write engine.
- Walks an external register table ROM and handles the I2C engine's sendit/done handshake.
- Inserts inter-write gaps and table-coded millisecond delays, retries NACKed writes, and reports completion or failure to the VGA/camera top level.

Parameters:
- ADDR_W, 8, ROM address width; the table holds at most 2^ADDR_W entries.
- NUM_ENTRIES, 255, hard upper bound on entries walked when no end marker is found.
- PWRUP_CYCLES, 500000, wait after start before the first write (20 ms at 25 MHz).
- GAP_CYCLES, 125, idle cycles between consecutive writes.
- MS_CYCLES, 25000, cycles per millisecond for delay entries.
- MAX_RETRY, 3, resends allowed per entry after a NACK.
- TIMEOUT_CYCLES, 262143, maximum cycles spent waiting on each i2c_done edge.

Ports:
- meg25  in  1  25 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a sequence when in IDLE, DONE or ERROR
- rom_addr  out  ADDR_W  table index
- rom_data  in  24  table word; valid 1 cycle after rom_addr changes (registered ROM)
- i2c_send_dat  out  24  word presented to the I2C engine
- i2c_sendit  out  1  transfer request to the I2C engine
- i2c_done  in  1  engine idle flag; async to meg25 (generated on the engine's sda_clk)
- i2c_ack  in  1  1 = NACK seen during the last transfer; async
- busy  out  1  sequence in progress
- initial_done  out  1  table completed successfully; sticky until next start or reset
- error  out  1  retries or timeout exhausted; sticky until next start or reset
- fail_index  out  ADDR_W  rom_addr of the failing entry; valid while error=1

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rom_addr=0, i2c_send_dat=0, i2c_sendit=0, busy=0, initial_done=0, error=0, fail_index=0, all counters 0.
- i2c_done and i2c_ack pass through 2-flop synchronisers; all references below mean the synchronised versions.
- States:
  - IDLE/DONE/ERROR: on start, clear initial_done, error and retry count; set rom_addr=0 and busy=1; go to PWRUP.
  - PWRUP: count PWRUP_CYCLES, then go to FETCH.
  - FETCH: wait 1 cycle for ROM latency, then go to DECODE.
  - DECODE:
    - rom_data[23:8]==16'hFFFE, or rom_addr==NUM_ENTRIES: go to DONE with initial_done=1, busy=0.
    - rom_data[23:8]==16'hFFFF: go to DELAY for rom_data[7:0]*MS_CYCLES cycles; value 0 means no delay. Then advance.
    - Otherwise: latch i2c_send_dat=rom_data, set i2c_sendit=1, go to WAIT_BUSY.
  - WAIT_BUSY: wait for i2c_done=0 (engine started), then go to WAIT_DONE.
  - WAIT_DONE: wait for i2c_done=1. On the first cycle it is seen, drop i2c_sendit to 0 and go to CHECK.
    - Sendit must fall in under 126 cycles (one bit period), otherwise the engine restarts the frame.
  - CHECK: sample i2c_ack.
    - ack=0: clear retry count, go to GAP, then advance.
    - ack=1 and retry<MAX_RETRY: increment retry, go to GAP, then resend the same entry (back to DECODE, same rom_addr).
    - ack=1 and retry==MAX_RETRY: go to ERROR with fail_index=rom_addr, error=1, busy=0.
  - GAP: count GAP_CYCLES.
  - Advance: rom_addr+1, then go to FETCH. rom_addr never wraps; the NUM_ENTRIES bound ends the sequence first.
- Timeout: a WAIT_BUSY or WAIT_DONE dwell longer than TIMEOUT_CYCLES goes to ERROR with i2c_sendit=0 and fail_index=rom_addr.
- i2c_sendit is 0 in every state except WAIT_BUSY and WAIT_DONE. i2c_send_dat is held stable from DECODE until CHECK.
- start while busy=1 is ignored.
- reset_n low mid-transfer forces i2c_sendit=0 immediately (async).
- A start pulse coincident with reset release is ignored.
- Delay counter width must hold 255*MS_CYCLES (23 bits at the default).

Test Plan:
- Table {0x310311, 0x300882, 0xFFFE00}, engine model ACKs all → two I2C frames carrying 0x310311 then 0x300882; sendit low within 3 cycles of each done rise; initial_done=1, busy=0, rom_addr=2.
- Table {0xFFFF05, 0x310311, 0xFFFE00} → first frame starts ≥5*25000 cycles after PWRUP ends; initial_done=1.
- Entry 1 NACKed twice, then ACKed (MAX_RETRY=3) → three frames of the same word, sequence completes, error=0.
- Entry 2 always NACKed → 4 frames of entry 2, then error=1, fail_index=2, initial_done=0, sendit=0.
- Engine model never drops done → after TIMEOUT_CYCLES error=1, fail_index=0; a subsequent start clears error and restarts at rom_addr=0.
- reset_n asserted during WAIT_DONE of entry 1 → sendit=0 immediately, all outputs at reset values; start pulsed in DECODE of entry 1 has no effect.
